multi_sprite_detection: RTL and testbench

MULTI_SPRITE_DETECTION -- requirements
Module: multi_sprite_detection

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_hit.sv | 35 +++
 rtl/multi_sprite_detection.sv | 156 +++++++++++++++
 tb/tb_multi_sprite_detection.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, clog2 helper and sprite position record for multi_sprite_detection.
// Latency: none (package only).
// Backpressure: none (package only).
package sprite_pkg;

    localparam int DEF_N_SPRITES = 4;
    localparam int DEF_SPRITE_W  = 32;
    localparam int DEF_SPRITE_H  = 32;
    localparam int DEF_COORD_W   = 10;
    // Position fields are stored at this width; unused high bits stay zero and are pruned.
    localparam int MAX_COORD_W   = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
        logic                   en;
    } sprite_pos_t;

endpackage

// File: rtl/sprite_hit.sv
// Per-sprite bounding-box test and in-sprite texel offset.
// Latency: combinational.
// Backpressure: none.
module sprite_hit import sprite_pkg::*; #(
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int SPRITE_H = DEF_SPRITE_H,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int DX_W     = clog2(SPRITE_W),
    parameter int DY_W     = clog2(SPRITE_H)
) (
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    input  sprite_pos_t        pos,
    output logic               hit,
    output logic [DX_W-1:0]    dx,
    output logic [DY_W-1:0]    dy
);

    localparam int SUM_W = MAX_COORD_W + 1;

    logic [SUM_W-1:0] px, py, x_lo, y_lo, x_hi, y_hi;

    // One extra bit on the upper bound so a sprite near the edge never wraps to column 0.
    assign px   = SUM_W'(vga_x);
    assign py   = SUM_W'(vga_y);
    assign x_lo = SUM_W'(pos.x);
    assign y_lo = SUM_W'(pos.y);
    assign x_hi = x_lo + SUM_W'(SPRITE_W);
    assign y_hi = y_lo + SUM_W'(SPRITE_H);

    assign hit = pos.en && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
    assign dx  = vga_x[DX_W-1:0] - pos.x[DX_W-1:0];
    assign dy  = vga_y[DY_W-1:0] - pos.y[DY_W-1:0];

endmodule

// File: rtl/multi_sprite_detection.sv
// Multi-sprite pixel hit detection with double-buffered positions (SPRITE_COLLISION_EN adds collision flag).
// Latency: outputs lag vga_x_in/vga_y_in by 2 cycles.
// Backpressure: pos_ready low during frame_start or reset; the source holds the write.
module multi_sprite_detection import sprite_pkg::*; #(
    parameter int N_SPRITES = DEF_N_SPRITES,
    parameter int SPRITE_W  = DEF_SPRITE_W,
    parameter int SPRITE_H  = DEF_SPRITE_H,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int IDX_W     = clog2(N_SPRITES),
    parameter int ROM_AW    = clog2(SPRITE_W * SPRITE_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] vga_x_in,
    input  logic [COORD_W-1:0] vga_y_in,
    input  logic               frame_start,
    input  logic               pos_wr,
    input  logic [IDX_W-1:0]   pos_idx,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               pos_en,
    output logic               pos_ready,
    output logic               square_there,
    output logic [IDX_W-1:0]   sprite_id,
    output logic [ROM_AW-1:0]  rom_coord,
    output logic               collision
);

    localparam int DX_W = clog2(SPRITE_W);
    localparam int DY_W = clog2(SPRITE_H);

    sprite_pos_t shadow [N_SPRITES];
    sprite_pos_t active [N_SPRITES];

    logic [N_SPRITES-1:0] hit_c, s1_hit;
    logic [DX_W-1:0]      dx_c [N_SPRITES];
    logic [DY_W-1:0]      dy_c [N_SPRITES];
    logic [DX_W-1:0]      s1_dx [N_SPRITES];
    logic [DY_W-1:0]      s1_dy [N_SPRITES];

    logic              win_hit;
    logic [IDX_W-1:0]  win_id;
    logic [ROM_AW-1:0] win_rom;
    logic              wr_ok;

    assign pos_ready = ~frame_start & ~reset;
    // Out-of-range indices are accepted but land nowhere.
    assign wr_ok     = pos_wr & pos_ready & (32'(pos_idx) < N_SPRITES);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_ok)
                shadow[pos_idx] <= '{x: MAX_COORD_W'(pos_x), y: MAX_COORD_W'(pos_y), en: pos_en};
            if (frame_start)
                active <= shadow;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .COORD_W  (COORD_W)
        ) u_sprite_hit (
            .vga_x (vga_x_in),
            .vga_y (vga_y_in),
            .pos   (active[g]),
            .hit   (hit_c[g]),
            .dx    (dx_c[g]),
            .dy    (dy_c[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else begin
            s1_hit <= hit_c;
            s1_dx  <= dx_c;
            s1_dy  <= dy_c;
        end
    end

    // Scan high to low so the lowest-index hitting sprite is the last to assign.
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        win_rom = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                win_hit = 1'b1;
                win_id  = IDX_W'(i);
                win_rom = {s1_dy[i], s1_dx[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            square_there <= 1'b0;
            sprite_id    <= '0;
            rom_coord    <= '0;
        end else begin
            square_there <= win_hit;
            sprite_id    <= win_id;
            if (win_hit)
                rom_coord <= win_rom;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic any_c, multi_c, s1_multi, coll_acc, collision_q;

    always_comb begin
        any_c   = 1'b0;
        multi_c = 1'b0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (hit_c[i]) begin
                if (any_c) multi_c = 1'b1;
                any_c = 1'b1;
            end
        end
    end

    // Sticky per-frame overlap flag, published and cleared at each frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_multi    <= 1'b0;
            coll_acc    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            s1_multi <= multi_c;
            if (frame_start) begin
                collision_q <= coll_acc | s1_multi;
                coll_acc    <= 1'b0;
            end else begin
                coll_acc <= coll_acc | s1_multi;
            end
        end
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sprite_detection.sv
// Scoreboard bench for multi_sprite_detection: expected pixel results queued at drive time,
// checked when the 2-cycle pipeline delivers them.
module tb_multi_sprite_detection;
    import sprite_pkg::*;

    localparam int IDX_W   = 2;
    localparam int ROM_AW  = 10;
    localparam int COORD_W = 10;
`ifdef SPRITE_COLLISION_EN
    localparam int COLL_EXP = 1;
`else
    localparam int COLL_EXP = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [COORD_W-1:0] vga_x_in = '0;
    logic [COORD_W-1:0] vga_y_in = '0;
    logic               frame_start = 1'b0;
    logic               pos_wr = 1'b0;
    logic [IDX_W-1:0]   pos_idx = '0;
    logic [COORD_W-1:0] pos_x = '0;
    logic [COORD_W-1:0] pos_y = '0;
    logic               pos_en = 1'b0;
    logic               pos_ready;
    logic               square_there;
    logic [IDX_W-1:0]   sprite_id;
    logic [ROM_AW-1:0]  rom_coord;
    logic               collision;

    always #5 clk = ~clk;

    multi_sprite_detection dut (
        .clk          (clk),
        .reset        (reset),
        .vga_x_in     (vga_x_in),
        .vga_y_in     (vga_y_in),
        .frame_start  (frame_start),
        .pos_wr       (pos_wr),
        .pos_idx      (pos_idx),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .pos_en       (pos_en),
        .pos_ready    (pos_ready),
        .square_there (square_there),
        .sprite_id    (sprite_id),
        .rom_coord    (rom_coord),
        .collision    (collision)
    );

    typedef struct {
        int                due;
        logic              sq;
        logic [IDX_W-1:0]  id;
        logic [ROM_AW-1:0] rom;
        bit                chk_rom;
        string             tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check_eq({e.tag, ".square_there"}, 32'(square_there), 32'(e.sq));
                check_eq({e.tag, ".sprite_id"}, 32'(sprite_id), 32'(e.id));
                if (e.chk_rom)
                    check_eq({e.tag, ".rom_coord"}, 32'(rom_coord), 32'(e.rom));
            end
        end
    end

    task automatic px(input int x, input int y, input logic sq, input int id, input int rom,
                      input bit chk, input string tag);
        @(negedge clk);
        vga_x_in = COORD_W'(x);
        vga_y_in = COORD_W'(y);
        sb.push_back('{due: cyc + 2, sq: sq, id: IDX_W'(id), rom: ROM_AW'(rom), chk_rom: chk, tag: tag});
    endtask

    task automatic write_pos(input int idx, input int x, input int y, input logic en);
        @(negedge clk);
        pos_wr  = 1'b1;
        pos_idx = IDX_W'(idx);
        pos_x   = COORD_W'(x);
        pos_y   = COORD_W'(y);
        pos_en  = en;
        #1 check_eq("pos_ready_idle", 32'(pos_ready), 32'd1);
        @(negedge clk);
        pos_wr = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        #1 check_eq("pos_ready_frame", 32'(pos_ready), 32'd0);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 8) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() > 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst.square_there", 32'(square_there), 32'd0);
        check_eq("rst.sprite_id", 32'(sprite_id), 32'd0);
        check_eq("rst.rom_coord", 32'(rom_coord), 32'd0);
        check_eq("rst.collision", 32'(collision), 32'd0);
        check_eq("rst.pos_ready", 32'(pos_ready), 32'd0);
        reset = 1'b0;
        #1 check_eq("pos_ready_after_rst", 32'(pos_ready), 32'd1);

        // Sprite 0 corners and edges, sprite 3 at the right screen edge
        write_pos(0, 100, 50, 1'b1);
        write_pos(3, 1020, 0, 1'b1);
        frame();
        px(100, 50, 1'b1, 0, 0, 1'b1, "top_left");
        px(131, 81, 1'b1, 0, 1023, 1'b1, "bottom_right");
        px(132, 50, 1'b0, 0, 0, 1'b0, "right_out");
        px(99, 50, 1'b0, 0, 0, 1'b0, "left_out");
        px(100, 82, 1'b0, 0, 0, 1'b0, "below_out");
        px(131, 50, 1'b1, 0, 31, 1'b1, "top_right");
        px(1023, 5, 1'b1, 3, 163, 1'b1, "screen_edge");
        drain();

        // Shadow writes stay invisible until frame_start
        write_pos(0, 100, 50, 1'b0);
        frame();
        write_pos(1, 110, 60, 1'b1);
        px(115, 65, 1'b0, 0, 0, 1'b0, "shadow_only");
        drain();
        frame();
        px(115, 65, 1'b1, 1, 165, 1'b1, "idx1_active");
        drain();

        // Overlap: lowest index wins, collision reported at next frame boundary
        write_pos(0, 100, 50, 1'b1);
        write_pos(2, 104, 54, 1'b1);
        frame();
        px(105, 55, 1'b1, 0, 165, 1'b1, "prio_0_over_2");
        px(120, 70, 1'b1, 0, 660, 1'b1, "prio_0_over_1_2");
        px(140, 85, 1'b1, 1, 830, 1'b1, "idx1_only");
        px(0, 0, 1'b0, 0, 0, 1'b0, "no_sprite");
        drain();
        frame();
        check_eq("collision_set", 32'(collision), 32'(COLL_EXP));
        repeat (3) @(negedge clk);
        frame();
        check_eq("collision_clean", 32'(collision), 32'd0);

        // Write coincident with frame_start is dropped
        @(negedge clk);
        pos_wr      = 1'b1;
        pos_idx     = 2'd1;
        pos_x       = 10'd300;
        pos_y       = 10'd300;
        pos_en      = 1'b1;
        frame_start = 1'b1;
        #1 check_eq("pos_ready_coincident", 32'(pos_ready), 32'd0);
        @(negedge clk);
        pos_wr      = 1'b0;
        frame_start = 1'b0;
        frame();
        px(305, 305, 1'b0, 0, 0, 1'b0, "dropped_write");
        px(115, 65, 1'b1, 0, 495, 1'b1, "sprite0_kept");
        drain();

        // Reset mid-frame beats frame_start and pos_wr
        px(100, 50, 1'b1, 0, 0, 1'b1, "pre_reset");
        drain();
        @(negedge clk);
        reset       = 1'b1;
        frame_start = 1'b1;
        pos_wr      = 1'b1;
        pos_idx     = 2'd3;
        pos_x       = 10'd100;
        pos_y       = 10'd50;
        pos_en      = 1'b1;
        #1 check_eq("pos_ready_in_reset", 32'(pos_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst.square_there", 32'(square_there), 32'd0);
        check_eq("mid_rst.sprite_id", 32'(sprite_id), 32'd0);
        check_eq("mid_rst.rom_coord", 32'(rom_coord), 32'd0);
        check_eq("mid_rst.collision", 32'(collision), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        frame_start = 1'b0;
        pos_wr      = 1'b0;
        frame();
        px(100, 50, 1'b0, 0, 0, 1'b0, "post_reset");
        px(1023, 5, 1'b0, 0, 0, 1'b0, "post_reset_edge");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
